multicycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the shared-datapath muxes and enables. It supersedes the single-cycle combinational decoder in the same datapath. It adds a ready/valid memory handshake with wait states, a BNE path, a bounded memory-timeout counter, and an illegal-opcode fault. It sits between the instruction register's opcode field and the multi-cycle datapath.

---
 rtl/multicycle_control_if.sv | 25 ++
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       MemReady;
    logic       MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe, RegWrite;
    logic       IorD, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, MemDataSize;
    logic       MemDataSign, InstrDone, Fault;
    logic [1:0] FaultCause;
    logic [3:0] State;

    modport master (
        input  opcode, MemReady,
        output MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe, RegWrite, IorD,
        output ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, MemDataSize,
        output MemDataSign, InstrDone, Fault, FaultCause, State
    );

    modport slave (
        output opcode, MemReady,
        input  MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe, RegWrite, IorD,
        input  ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, MemDataSize,
        input  MemDataSign, InstrDone, Fault, FaultCause, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing with
// ready/valid memory wait states, bounded access timeout and a sticky fault state.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input logic                 clk,
    input logic                 reset_n,
    multicycle_control_if.master ctrl
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
        StMemWb  = 4'd4,  StMemWr  = 4'd5,  StRExec  = 4'd6,  StRWb    = 4'd7,
        StBranch = 4'd8,  StJump   = 4'd9,  StIExec  = 4'd10, StIWb    = 4'd11,
        StFault  = 4'd15
    } state_e;

    localparam logic [5:0] OpRformat = 6'd0,  OpJ    = 6'd2,  OpJal  = 6'd3,  OpBeq  = 6'd4;
    localparam logic [5:0] OpBne     = 6'd5,  OpAddi = 6'd8,  OpAndi = 6'd12, OpLb   = 6'd32;
    localparam logic [5:0] OpLh      = 6'd33, OpLw   = 6'd35, OpLbu  = 6'd36, OpLhu  = 6'd37;
    localparam logic [5:0] OpSb      = 6'd40, OpSh   = 6'd41, OpSw   = 6'd43;

    localparam bit             ToEn   = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] ToLast = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_fault;
    logic [1:0]       r_cause, w_cause;

    logic       w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_write_cond, w_branch_ne;
    logic       w_reg_write, w_iord, w_alu_src_a, w_done, w_sign, w_timeout, w_is_load;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source, w_reg_dst, w_mem_to_reg, w_size;

    assign w_is_load = ctrl.opcode inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    assign w_timeout = ToEn && (r_cnt == ToLast) && !ctrl.MemReady;

    always_comb begin
        w_next          = r_state;
        w_cause         = 2'b00;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_ne     = 1'b0;
        w_reg_write     = 1'b0;
        w_iord          = 1'b0;
        w_alu_src_a     = 1'b0;
        w_done          = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_reg_dst       = 2'b00;
        w_mem_to_reg    = 2'b00;
        unique case (r_state)
            StFetch: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (ctrl.MemReady) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = StDecode;
                end else if (w_timeout) begin
                    w_next  = StFault;
                    w_cause = 2'b10;
                end
            end
            StDecode: begin
                w_alu_src_b = 2'b11;
                case (ctrl.opcode)
                    OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: w_next = StMemAdr;
                    OpRformat:                                        w_next = StRExec;
                    OpBeq, OpBne:                                     w_next = StBranch;
                    OpJ, OpJal:                                       w_next = StJump;
                    OpAddi, OpAndi:                                   w_next = StIExec;
                    default: begin
                        w_next  = StFault;
                        w_cause = 2'b01;
                    end
                endcase
            end
            StMemAdr: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = w_is_load ? StMemRd : StMemWr;
            end
            StMemRd: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (ctrl.MemReady) begin
                    w_next = StMemWb;
                end else if (w_timeout) begin
                    w_next  = StFault;
                    w_cause = 2'b10;
                end
            end
            StMemWb: begin
                w_mem_to_reg = 2'b01;
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_next       = StFetch;
            end
            StMemWr: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (ctrl.MemReady) begin
                    w_done = 1'b1;
                    w_next = StFetch;
                end else if (w_timeout) begin
                    w_next  = StFault;
                    w_cause = 2'b10;
                end
            end
            StRExec: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = StRWb;
            end
            StRWb: begin
                w_reg_dst   = 2'b01;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = StFetch;
            end
            StBranch: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_branch_ne     = (ctrl.opcode == OpBne);
                w_done          = 1'b1;
                w_next          = StFetch;
            end
            StJump: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                if (ctrl.opcode == OpJal) begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = 2'b10;
                    w_mem_to_reg = 2'b10;
                end
                w_done = 1'b1;
                w_next = StFetch;
            end
            StIExec: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = (ctrl.opcode == OpAndi) ? 2'b11 : 2'b00;
                w_next      = StIWb;
            end
            StIWb: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = StFetch;
            end
            StFault: w_next = StFault;
            default: w_next = StFetch;
        endcase
    end

    // Access size/sign only matter while a load/store is in flight.
    always_comb begin
        w_size = 2'b00;
        w_sign = 1'b0;
        if (r_state inside {StMemAdr, StMemRd, StMemWb, StMemWr}) begin
            case (ctrl.opcode)
                OpLw, OpSw:        w_size = 2'b11;
                OpLh, OpLhu, OpSh: w_size = 2'b10;
                OpLb, OpLbu, OpSb: w_size = 2'b01;
                default:           w_size = 2'b00;
            endcase
            w_sign = ctrl.opcode inside {OpLw, OpLh, OpLb, OpSw, OpSh, OpSb};
        end
    end

    // Counter is zero on every entry to an access state and counts its wait cycles.
    always_comb begin
        w_cnt_next = '0;
        if ((r_state inside {StFetch, StMemRd, StMemWr}) && (w_next == r_state)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StFetch;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if ((w_next == StFault) && (r_state != StFault)) begin
                r_fault <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    // Reset kills every decoded output at once, so no write-back survives an abort.
    assign ctrl.MemRead     = reset_n & w_mem_read;
    assign ctrl.MemWrite    = reset_n & w_mem_write;
    assign ctrl.IRWrite     = reset_n & w_ir_write;
    assign ctrl.PCWrite     = reset_n & w_pc_write;
    assign ctrl.PCWriteCond = reset_n & w_pc_write_cond;
    assign ctrl.BranchNe    = reset_n & w_branch_ne;
    assign ctrl.RegWrite    = reset_n & w_reg_write;
    assign ctrl.IorD        = reset_n & w_iord;
    assign ctrl.ALUSrcA     = reset_n & w_alu_src_a;
    assign ctrl.ALUSrcB     = reset_n ? w_alu_src_b  : 2'b00;
    assign ctrl.ALUOp       = reset_n ? w_alu_op     : 2'b00;
    assign ctrl.PCSource    = reset_n ? w_pc_source  : 2'b00;
    assign ctrl.RegDst      = reset_n ? w_reg_dst    : 2'b00;
    assign ctrl.MemtoReg    = reset_n ? w_mem_to_reg : 2'b00;
    assign ctrl.MemDataSize = reset_n ? w_size       : 2'b00;
    assign ctrl.MemDataSign = reset_n & w_sign;
    assign ctrl.InstrDone   = reset_n & w_done;
    assign ctrl.Fault       = r_fault;
    assign ctrl.FaultCause  = r_cause;
    assign ctrl.State       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written corner sequences and
// randomized instruction streams checked against a route-based reference model.
module tb_multicycle_control;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    multicycle_control_if ifc ();

    multicycle_control #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ctrl   (ifc.master)
    );

    always #5 clk = ~clk;

    // en = {MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe, RegWrite, IorD, ALUSrcA}
    // sel = {ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, MemDataSize}
    typedef struct packed {
        logic [8:0]  en;
        logic [11:0] sel;
        logic        sign;
        logic        done;
        logic        fault;
        logic [1:0]  cause;
        logic [3:0]  st;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [8:0]  en;
        logic [11:0] sel;
        logic        sign;
        logic        done;
        logic [3:0]  st;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    int         m_route[$];
    int         m_pos, m_waits, fault_cycles;
    logic [1:0] m_cause;
    logic       m_new;
    logic [5:0] legal[15] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd12, 6'd32, 6'd33, 6'd35,
                              6'd36, 6'd37, 6'd40, 6'd41, 6'd43};

    function automatic outs_t mk(logic [8:0] en, logic [11:0] sel, logic sign, logic done,
                                 logic fault, logic [1:0] cause, logic [3:0] st);
        outs_t o;
        o.en = en; o.sel = sel; o.sign = sign; o.done = done;
        o.fault = fault; o.cause = cause; o.st = st;
        return o;
    endfunction

    function automatic outs_t act();
        return mk({ifc.MemRead, ifc.MemWrite, ifc.IRWrite, ifc.PCWrite, ifc.PCWriteCond,
                   ifc.BranchNe, ifc.RegWrite, ifc.IorD, ifc.ALUSrcA},
                  {ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.RegDst, ifc.MemtoReg,
                   ifc.MemDataSize},
                  ifc.MemDataSign, ifc.InstrDone, ifc.Fault, ifc.FaultCause, ifc.State);
    endfunction

    task automatic chk(input string name, input outs_t exp);
        outs_t a;
        a = act();
        n_vec++;
        if (a !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got en=%b sel=%b sg=%b dn=%b f=%b c=%b st=%0d want en=%b sel=%b sg=%b dn=%b f=%b c=%b st=%0d",
                     name, $time, a.en, a.sel, a.sign, a.done, a.fault, a.cause, a.st,
                     exp.en, exp.sel, exp.sign, exp.done, exp.fault, exp.cause, exp.st);
        end
    endtask

    // Behavioural expectation for a given spec state number and opcode.
    function automatic outs_t model_out(int st, logic [5:0] op, logic rdy, logic [1:0] cause);
        logic mr, mw, ir, pw, pwc, bne, rw, iord, asa, sg, dn;
        logic [1:0] asb, aop, pcs, rd, m2r, sz;
        {mr, mw, ir, pw, pwc, bne, rw, iord, asa, sg, dn} = '0;
        {asb, aop, pcs, rd, m2r, sz} = '0;
        if (st >= 2 && st <= 5) begin
            if (op == 35 || op == 43) sz = 2'b11;
            else if (op == 33 || op == 37 || op == 41) sz = 2'b10;
            else sz = 2'b01;
            sg = (op == 35 || op == 33 || op == 32 || op == 43 || op == 41 || op == 40);
        end
        case (st)
            0:  begin mr = 1; asb = 2'b01; ir = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 2'b01; rw = 1; dn = 1; end
            5:  begin mw = 1; iord = 1; dn = rdy; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 2'b01; rw = 1; dn = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; bne = (op == 5); dn = 1; end
            9:  begin
                pw = 1; pcs = 2'b10; dn = 1;
                if (op == 3) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
            end
            10: begin asa = 1; asb = 2'b10; aop = (op == 12) ? 2'b11 : 2'b00; end
            11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return mk({mr, mw, ir, pw, pwc, bne, rw, iord, asa}, {asb, aop, pcs, rd, m2r, sz},
                  sg, dn, (st == 15), cause, 4'(st));
    endfunction

    function automatic void build(logic [5:0] op);
        m_route = '{0, 1};
        case (op)
            32, 33, 35, 36, 37: begin m_route.push_back(2); m_route.push_back(3);
                                      m_route.push_back(4); end
            40, 41, 43:         begin m_route.push_back(2); m_route.push_back(5); end
            0:                  begin m_route.push_back(6); m_route.push_back(7); end
            4, 5:               m_route.push_back(8);
            2, 3:               m_route.push_back(9);
            8, 12:              begin m_route.push_back(10); m_route.push_back(11); end
            default:            m_route.push_back(15);
        endcase
    endfunction

    // Called at posedge+1; leaves the DUT in its first FETCH cycle at posedge+1.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset", mk('0, '0, 0, 0, 0, 2'b00, 4'd0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input outs_t exp);
        ifc.opcode   = op;
        ifc.MemReady = rdy;
        @(negedge clk);
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0]  FetchEn   = 9'b101100000;
    localparam logic [8:0]  FetchWait = 9'b100000000;
    localparam logic [11:0] FetchSel  = 12'b01_00_00_00_00_00;
    localparam logic [11:0] DecSel    = 12'b11_00_00_00_00_00;

    vec_t tbl[29];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        logic       rdy;
        int         st;

        tbl[0]  = '{6'd0,  1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[1]  = '{6'd0,  1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[2]  = '{6'd0,  1, 9'b000000001, 12'b00_10_00_00_00_00,   0, 0, 4'd6};
        tbl[3]  = '{6'd0,  1, 9'b000000100, 12'b00_00_00_01_00_00,   0, 1, 4'd7};
        tbl[4]  = '{6'd37, 1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[5]  = '{6'd37, 1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[6]  = '{6'd37, 1, 9'b000000001, 12'b10_00_00_00_00_10,   0, 0, 4'd2};
        tbl[7]  = '{6'd37, 0, 9'b100000010, 12'b00_00_00_00_00_10,   0, 0, 4'd3};
        tbl[8]  = '{6'd37, 0, 9'b100000010, 12'b00_00_00_00_00_10,   0, 0, 4'd3};
        tbl[9]  = '{6'd37, 0, 9'b100000010, 12'b00_00_00_00_00_10,   0, 0, 4'd3};
        tbl[10] = '{6'd37, 1, 9'b100000010, 12'b00_00_00_00_00_10,   0, 0, 4'd3};
        tbl[11] = '{6'd37, 1, 9'b000000100, 12'b00_00_00_00_01_10,   0, 1, 4'd4};
        tbl[12] = '{6'd5,  1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[13] = '{6'd5,  1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[14] = '{6'd5,  1, 9'b000011001, 12'b00_01_01_00_00_00,   0, 1, 4'd8};
        tbl[15] = '{6'd3,  1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[16] = '{6'd3,  1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[17] = '{6'd3,  1, 9'b000100100, 12'b00_00_10_10_10_00,   0, 1, 4'd9};
        tbl[18] = '{6'd43, 1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[19] = '{6'd43, 1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[20] = '{6'd43, 1, 9'b000000001, 12'b10_00_00_00_00_11,   1, 0, 4'd2};
        tbl[21] = '{6'd43, 0, 9'b010000010, 12'b00_00_00_00_00_11,   1, 0, 4'd5};
        tbl[22] = '{6'd43, 1, 9'b010000010, 12'b00_00_00_00_00_11,   1, 1, 4'd5};
        tbl[23] = '{6'd12, 1, FetchEn,      FetchSel,                0, 0, 4'd0};
        tbl[24] = '{6'd12, 1, 9'b0,         DecSel,                  0, 0, 4'd1};
        tbl[25] = '{6'd12, 1, 9'b000000001, 12'b10_11_00_00_00_00,   0, 0, 4'd10};
        tbl[26] = '{6'd12, 1, 9'b000000100, 12'b0,                   0, 1, 4'd11};
        tbl[27] = '{6'd0,  0, FetchWait,    FetchSel,                0, 0, 4'd0};
        tbl[28] = '{6'd0,  1, FetchEn,      FetchSel,                0, 0, 4'd0};

        ifc.opcode   = 6'd0;
        ifc.MemReady = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 29; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].op, tbl[i].rdy,
                 mk(tbl[i].en, tbl[i].sel, tbl[i].sign, tbl[i].done, 0, 2'b00, tbl[i].st));
        end

        // Illegal opcode: sticky fault, held through 20 cycles, cleared only by reset.
        do_reset();
        step("ill_fetch", 6'h3F, 1, mk(FetchEn, FetchSel, 0, 0, 0, 2'b00, 4'd0));
        step("ill_decode", 6'h3F, 1, mk(9'b0, DecSel, 0, 0, 0, 2'b00, 4'd1));
        for (int i = 0; i < 20; i++) begin
            step("ill_hold", 6'h3F, 1'($urandom_range(0, 1)),
                 mk(9'b0, 12'b0, 0, 0, 1, 2'b01, 4'd15));
        end
        do_reset();

        // Fetch timeout after TO wait cycles, then the same with MemReady on the last one.
        for (int i = 0; i < int'(TO); i++) begin
            step("to_wait", 6'd0, 0, mk(FetchWait, FetchSel, 0, 0, 0, 2'b00, 4'd0));
        end
        step("to_fault", 6'd0, 0, mk(9'b0, 12'b0, 0, 0, 1, 2'b10, 4'd15));
        do_reset();
        for (int i = 0; i < int'(TO) - 1; i++) begin
            step("to_wait2", 6'd0, 0, mk(FetchWait, FetchSel, 0, 0, 0, 2'b00, 4'd0));
        end
        step("to_last_ready", 6'd0, 1, mk(FetchEn, FetchSel, 0, 0, 0, 2'b00, 4'd0));
        step("to_no_fault", 6'd0, 1, mk(9'b0, DecSel, 0, 0, 0, 2'b00, 4'd1));
        step("to_rexec", 6'd0, 1, mk(9'b000000001, 12'b00_10_00_00_00_00, 0, 0, 0, 2'b00, 4'd6));
        step("to_rwb", 6'd0, 1, mk(9'b000000100, 12'b00_00_00_01_00_00, 0, 1, 0, 2'b00, 4'd7));

        // Reset asserted in the middle of MEMWB must kill RegWrite at once.
        do_reset();
        step("lw_fetch", 6'd35, 1, mk(FetchEn, FetchSel, 0, 0, 0, 2'b00, 4'd0));
        step("lw_decode", 6'd35, 1, mk(9'b0, DecSel, 0, 0, 0, 2'b00, 4'd1));
        step("lw_adr", 6'd35, 1, mk(9'b000000001, 12'b10_00_00_00_00_11, 1, 0, 0, 2'b00, 4'd2));
        step("lw_rd", 6'd35, 1, mk(9'b100000010, 12'b00_00_00_00_00_11, 1, 0, 0, 2'b00, 4'd3));
        @(negedge clk);
        chk("lw_wb", mk(9'b000000100, 12'b00_00_00_00_01_11, 1, 1, 0, 2'b00, 4'd4));
        #1;
        reset_n = 1'b0;
        #1;
        chk("wb_abort", mk('0, '0, 0, 0, 0, 2'b00, 4'd0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized instruction stream against the route model.
        m_new = 1'b1;
        m_pos = 0;
        m_waits = 0;
        m_cause = 2'b00;
        fault_cycles = 0;
        op = 6'd0;
        for (int c = 0; c < 4000; c++) begin
            if (m_new) begin
                if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
                else op = legal[$urandom_range(0, 14)];
                build(op);
                m_new = 1'b0;
                m_pos = 0;
                m_waits = 0;
            end
            st = m_route[m_pos];
            rdy = ($urandom_range(0, 9) < 7);
            step("random", op, rdy, model_out(st, op, rdy, m_cause));
            if (st == 15) begin
                fault_cycles++;
                if (fault_cycles == 3) begin
                    do_reset();
                    m_new = 1'b1;
                    m_cause = 2'b00;
                    fault_cycles = 0;
                end
            end else if ((st == 0 || st == 3 || st == 5) && !rdy) begin
                if (m_waits == int'(TO) - 1) begin
                    m_route = '{15};
                    m_pos = 0;
                    m_cause = 2'b10;
                end else begin
                    m_waits++;
                end
            end else begin
                m_waits = 0;
                m_pos++;
                if (m_pos == m_route.size()) m_new = 1'b1;
                else if (m_route[m_pos] == 15) m_cause = 2'b01;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
